// File: rtl/lift_scan_ctrl_if.sv
// Call/status bundle between lift_scan_ctrl and its call sources and drivers.
// With LIFT_ESTOP_EN defined the bundle also carries the estop request.
interface lift_scan_ctrl_if #(
  parameter int N_FLOORS = 4
);
  localparam int FW = $clog2(N_FLOORS);

  logic [N_FLOORS-1:0] call_req;
  logic [FW-1:0]       floor;
  logic                dir_up;
  logic                moving;
  logic                door_open;
  logic [N_FLOORS-1:0] pending;
`ifdef LIFT_ESTOP_EN
  logic                estop;

  modport master (output call_req, estop,
                  input  floor, dir_up, moving, door_open, pending);
  modport slave  (input  call_req, estop,
                  output floor, dir_up, moving, door_open, pending);
`else
  modport master (output call_req,
                  input  floor, dir_up, moving, door_open, pending);
  modport slave  (input  call_req,
                  output floor, dir_up, moving, door_open, pending);
`endif
endinterface

// File: rtl/lift_scan_ctrl.sv
// N-floor SCAN lift controller: latches calls, serves them direction-first,
// times travel and door dwell from a prescaler. Optional estop via LIFT_ESTOP_EN.
module lift_scan_ctrl #(
  parameter int N_FLOORS     = 4,
  parameter int HOME_FLOOR   = 1,
  parameter int TICK_DIV     = 50000000,
  parameter int TRAVEL_TICKS = 1,
  parameter int DOOR_TICKS   = 2
) (
  input logic             clk,
  input logic             rst_n,
  lift_scan_ctrl_if.slave bus
);
  localparam int FW     = $clog2(N_FLOORS);
  localparam int PW     = $clog2(TICK_DIV);
  localparam int PH_MAX = (TRAVEL_TICKS > DOOR_TICKS) ? TRAVEL_TICKS : DOOR_TICKS;
  localparam int PHW    = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MOVE = 2'd1,
    S_DOOR = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [FW-1:0]       floor_q, floor_d;
  logic                dir_q, dir_d;
  logic [N_FLOORS-1:0] pending_q, pending_d;
  logic [PW-1:0]       presc_q, presc_d;
  logic [PHW-1:0]      phase_q, phase_d;

  logic [N_FLOORS-1:0] set_mask, clr_mask, above, below;
  logic                tick, ahead_up, ahead_dn;
  int unsigned         floor_u;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      floor_q   <= FW'(HOME_FLOOR);
      dir_q     <= 1'b1;
      pending_q <= '0;
      presc_q   <= '0;
      phase_q   <= '0;
    end else begin
      state_q   <= state_d;
      floor_q   <= floor_d;
      dir_q     <= dir_d;
      pending_q <= pending_d;
      presc_q   <= presc_d;
      phase_q   <= phase_d;
    end
  end

  always_comb begin
    floor_u = 32'(floor_q);
    above   = '0;
    below   = '0;
    for (int unsigned i = 0; i < N_FLOORS; i++) begin
      above[i] = (i > floor_u);
      below[i] = (i < floor_u);
    end
  end

  assign tick     = (presc_q == PW'(TICK_DIV - 1));
  assign ahead_up = |(pending_q & above);
  assign ahead_dn = |(pending_q & below);

  always_comb begin
    state_d  = state_q;
    floor_d  = floor_q;
    dir_d    = dir_q;
    presc_d  = presc_q;
    phase_d  = phase_q;
    clr_mask = '0;
    set_mask = bus.call_req;
    // A call at the current floor is served by the door, never latched, unless travelling.
    if (state_q != S_MOVE) set_mask[floor_q] = 1'b0;

    case (state_q)
      S_IDLE: begin
        presc_d = '0;
        phase_d = '0;
        if (bus.call_req[floor_q]) begin
          state_d           = S_DOOR;
          clr_mask[floor_q] = 1'b1;
        end else if (|pending_q) begin
          state_d = S_MOVE;
          if (floor_q == '0)                       dir_d = 1'b1;
          else if (floor_q == FW'(N_FLOORS - 1))   dir_d = 1'b0;
          else if (dir_q ? !ahead_up : !ahead_dn)  dir_d = !dir_q;
        end
      end

      S_MOVE: begin
        presc_d = tick ? '0 : presc_q + PW'(1);
        if (tick) begin
          if (phase_q == PHW'(TRAVEL_TICKS - 1)) begin
            phase_d = '0;
            floor_d = dir_q ? floor_q + FW'(1) : floor_q - FW'(1);
            if (pending_q[floor_d]) begin
              clr_mask[floor_d] = 1'b1;
              state_d           = S_DOOR;
            end
          end else begin
            phase_d = phase_q + PHW'(1);
          end
        end
      end

      S_DOOR: begin
        if (bus.call_req[floor_q]) begin
          presc_d = '0;
          phase_d = '0;
        end else begin
          presc_d = tick ? '0 : presc_q + PW'(1);
          if (tick) begin
            if (phase_q == PHW'(DOOR_TICKS - 1)) begin
              phase_d = '0;
              state_d = S_IDLE;
            end else begin
              phase_d = phase_q + PHW'(1);
            end
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

`ifdef LIFT_ESTOP_EN
    // Freeze overrides every transition but leaves call latching untouched.
    if (bus.estop) begin
      state_d  = state_q;
      floor_d  = floor_q;
      dir_d    = dir_q;
      presc_d  = presc_q;
      phase_d  = phase_q;
      clr_mask = '0;
    end
`endif

    pending_d = (pending_q | set_mask) & ~clr_mask;
  end

  assign bus.floor     = floor_q;
  assign bus.dir_up    = dir_q;
  assign bus.moving    = (state_q == S_MOVE);
  assign bus.door_open = (state_q == S_DOOR);
  assign bus.pending   = pending_q;
endmodule

// File: doc/lift_scan_ctrl.md
Name: lift_scan_ctrl

Overview:
- Parametrised N-floor lift controller; next generation of the fixed 3-floor board-level lift FSM.
- Latches floor calls, serves them in SCAN order (keeps direction while calls remain ahead), times travel and door dwell from a built-in prescaler.
- Sits between debounced/synchronised call inputs (buttons, GPIO) and display/motor/door drivers.

Parameters:
- N_FLOORS, 4, number of floors, 2..32; floor 0 is the lowest.
- HOME_FLOOR, 1, floor index loaded at reset.
- TICK_DIV, 50000000, clk cycles per timing tick (2..2^26).
- TRAVEL_TICKS, 1, ticks to move one floor (>=1).
- DOOR_TICKS, 2, ticks the door stays open (>=1).
- FW, $clog2(N_FLOORS), floor index width (derived, not overridden).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- call_req  in  N_FLOORS  level/pulse call per floor, active high, already synchronous to clk
- floor  out  FW  current floor index
- dir_up  out  1  1 = travelling/preferring up, 0 = down
- moving  out  1  1 while in MOVE
- door_open  out  1  1 while in DOOR
- pending  out  N_FLOORS  latched, unserved calls

Behaviour:
- One clock; reset is asynchronous and active-low: clk and rst_n.
- Reset (any time, including mid-move or door open): state=IDLE, floor=HOME_FLOOR, dir_up=1, moving=0, door_open=0, pending=0, prescaler=0, phase counter=0.
- Prescaler: counts 0..TICK_DIV-1, tick pulse when count==TICK_DIV-1; restarts at 0 on every entry into MOVE or DOOR and on each floor step, so timing is exact.
- pending[i] set at the edge where call_req[i]=1, except i==floor while in IDLE or DOOR (served directly, never latched).
- States: IDLE, MOVE, DOOR (moving/door_open registered from state).
- IDLE: call_req[floor]=1 -> DOOR next edge. Else if pending!=0: ahead = pending bits above floor (dir_up=1) or below (dir_up=0); if ahead nonempty keep dir, else flip dir_up; -> MOVE. A call at another floor therefore gives moving=1 two edges after call_req is sampled.
- MOVE: phase counter increments per tick; at tick with phase==TRAVEL_TICKS-1, floor +=1 or -=1, phase=0. If pending[new floor]=1 on that same edge: clear that bit and -> DOOR (door_open=1 that edge); else stay MOVE in same direction. One floor takes exactly TRAVEL_TICKS*TICK_DIV cycles.
- DOOR: on entry pending[floor] is cleared. Phase counts ticks; at tick with phase==DOOR_TICKS-1 -> IDLE. call_req[floor]=1 during DOOR restarts prescaler and phase (door held open). Open time = DOOR_TICKS*TICK_DIV cycles from last restart.
- Boundaries: floor never leaves 0..N_FLOORS-1 (direction choice guarantees a target ahead); at floor 0 dir_up forced 1 on departure, at N_FLOORS-1 forced 0.
- Simultaneous: set and clear of the same pending bit on one edge -> clear wins; multiple new calls on one edge all latch.
- call_req bits held high continuously behave as repeated calls (door at that floor stays open until released).

Optional Feature:
- LIFT_ESTOP_EN: adds input port estop (1 bit, active high). While estop=1: prescaler and phase frozen, state/floor/dir held, IDLE makes no transition; pending still latches calls. On release, timing resumes from the frozen count.
- Without the macro: no estop port; no freeze logic.

Test Plan (N_FLOORS=4, HOME_FLOOR=1, TICK_DIV=4, TRAVEL_TICKS=2, DOOR_TICKS=3):
- Release reset -> floor=1, dir_up=1, moving=0, door_open=0, pending=0000; assert rst_n=0 mid-MOVE -> same values immediately, asynchronously.
- 1-cycle pulse call_req=1000 in IDLE -> pending=1000 next edge, moving=1 one edge later; floor 2 after 8 cycles, floor 3 after 16, door_open=1 same edge as floor=3, pending=0000; door closes 12 cycles later.
- From floor 3, pulse call_req=0001 and 0100 same edge -> dir_up flips to 0, door opens at floor 2 (pending 0001 remains), then 0 -> pending=0000.
- In IDLE at floor 1 pulse call_req=0010 -> door_open=1 next edge, pending stays 0000; repeat pulse at cycle 10 of dwell -> door closes 12 cycles after repeat.
- At floor 1 moving up to 3, pulse call_req=0001 -> continues up, serves 3, then reverses to 0; no extra stop at 1 or 2.
- LIFT_ESTOP_EN: estop=1 for 20 cycles mid-travel -> floor/phase unchanged throughout, arrival delayed by exactly 20 cycles.
